// File: rtl/axi_pkg.sv
// Shared types for the AXI write-slave: burst kinds, response codes, FSM states.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_SIZE = 32
) (
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  burst_e               burst_i,
  input  logic [2:0]           size_i,
  input  logic [3:0]           len_i,
  output logic [ADDR_SIZE-1:0] next_addr_o
);

  logic [ADDR_SIZE-1:0] step, incr_addr, wrap_mask;

  assign step      = ADDR_SIZE'(1) << size_i;
  assign incr_addr = addr_i + step;
  // Wrap window is (len+1)*step bytes; legal wrap lengths make it a power of two.
  assign wrap_mask = ((ADDR_SIZE'(len_i) + ADDR_SIZE'(1)) << size_i) - ADDR_SIZE'(1);

  always_comb begin
    next_addr_o = addr_i;
    case (burst_i)
      BURST_INCR: next_addr_o = incr_addr;
      BURST_WRAP: next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_wr_slave_mem.sv
// Single-outstanding AXI3 write slave backed by a byte-strobed word memory.
// Define AXI_WR_SLV_WLAST_CHK_EN to flag misplaced/missing wlast as SLVERR.
module axi_wr_slave_mem
  import axi_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int STRB_SIZE = DATA_SIZE / 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         aclk,
  input  logic                         arst,
  input  logic [ADDR_SIZE-1:0]         awaddr,
  input  logic [3:0]                   awid,
  input  logic [3:0]                   awlen,
  input  logic [1:0]                   awburst,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awlock,
  input  logic [1:0]                   awcache,
  input  logic [2:0]                   awprot,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_SIZE-1:0]         wdata,
  input  logic [STRB_SIZE-1:0]         wstrb,
  input  logic [3:0]                   wid,
  input  logic                         wvalid,
  input  logic                         wlast,
  output logic                         wready,
  output logic [3:0]                   bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_SIZE-1:0]         dbg_rdata
);

  localparam int ADDR_LSB = $clog2(STRB_SIZE);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] MEM_BYTES = (ADDR_SIZE+1)'(MEM_DEPTH * STRB_SIZE);

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d, next_addr;
  logic [3:0]           id_q, id_d, len_q, len_d, cnt_q, cnt_d;
  burst_e               burst_q, burst_d;
  logic [2:0]           size_q, size_d;
  logic                 err_q, err_d, drop_q, drop_d;
  logic                 awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [3:0]           bid_q, bid_d;
  logic [1:0]           bresp_q, bresp_d;

  logic                 aw_hs, w_hs, b_hs, last_beat;
  logic                 aw_bad, in_range, beat_ok, last_err, mem_we;
  logic [7:0]           aw_step;
  burst_e               aw_burst;

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  logic unused_sig;
  assign unused_sig = ^{awlock, awcache, awprot, wlast};

  assign aw_hs     = awvalid & awready_q;
  assign w_hs      = wvalid & wready_q;
  assign b_hs      = bvalid_q & bready;
  assign last_beat = (cnt_q == len_q);

  // Burst-level faults: every beat is still accepted, none is written.
  assign aw_burst = burst_e'(awburst);
  assign aw_step  = 8'd1 << awsize;
  assign aw_bad   = (aw_burst == BURST_RSVD)
                  | ((aw_burst == BURST_WRAP) & ~wrap_len_ok(awlen))
                  | (int'(aw_step) > STRB_SIZE)
                  | ((aw_burst == BURST_WRAP) & |(awaddr & (ADDR_SIZE'(aw_step) - ADDR_SIZE'(1))));

  assign in_range = ({1'b0, addr_q} < MEM_BYTES);
  assign beat_ok  = in_range & (wid == id_q);
  assign mem_we   = w_hs & ~drop_q & beat_ok;

`ifdef AXI_WR_SLV_WLAST_CHK_EN
  assign last_err = (wlast != last_beat);
`else
  assign last_err = 1'b0;
`endif

  axi_burst_addr_gen #(.ADDR_SIZE(ADDR_SIZE)) u_addr_gen (
    .addr_i      (addr_q),
    .burst_i     (burst_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .next_addr_o (next_addr)
  );

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      id_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= BURST_FIXED;
      size_q    <= '0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      size_q    <= size_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (aw_hs)              state_d = ST_DATA;
      ST_DATA: if (w_hs && last_beat)  state_d = ST_RESP;
      ST_RESP: if (b_hs)               state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    size_d  = size_q;
    err_d   = err_q;
    drop_d  = drop_q;
    if (state_q == ST_IDLE && aw_hs) begin
      addr_d  = awaddr;
      id_d    = awid;
      len_d   = awlen;
      cnt_d   = '0;
      burst_d = aw_burst;
      size_d  = awsize;
      err_d   = aw_bad;
      drop_d  = aw_bad;
    end else if (state_q == ST_DATA && w_hs) begin
      addr_d = next_addr;
      cnt_d  = cnt_q + 4'd1;
      if (!beat_ok || last_err) err_d = 1'b1;
    end
  end

  // Handshake outputs are registered decodes of the next state.
  always_comb begin
    awready_d = (state_d == ST_IDLE);
    wready_d  = (state_d == ST_DATA);
    bvalid_d  = (state_d == ST_RESP);
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    if (state_q == ST_DATA && state_d == ST_RESP) begin
      bid_d   = id_q;
      bresp_d = err_d ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_SIZE; b++) begin
        if (wstrb[b]) mem[addr_q[ADDR_LSB +: IDX_W]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign dbg_rdata = mem[dbg_addr];

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Directed bench for axi_wr_slave_mem: bursts, bounds, backpressure and mid-burst reset.
module tb_axi_wr_slave_mem;

  logic        aclk = 1'b0;
  logic        arst;
  logic [31:0] awaddr;
  logic [3:0]  awid, awlen;
  logic [1:0]  awburst;
  logic [2:0]  awsize;
  logic [1:0]  awlock, awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb, wid;
  logic        wvalid, wlast, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi_wr_slave_mem dut (
    .aclk(aclk), .arst(arst),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awburst(awburst), .awsize(awsize),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wid(wid), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [3:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    awaddr = a; awid = id; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    while (!awready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("aw_timeout", 64'(awready), 64'd1);
    tick();
    awvalid = 1'b0;
    chk("wready_after_aw", 64'(wready), 64'd1);
    chk("awready_in_data", 64'(awready), 64'd0);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic [3:0] id,
                        input logic last);
    int n = 0;
    wdata = d; wstrb = s; wid = id; wlast = last; wvalid = 1'b1;
    while (!wready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("w_timeout", 64'(wready), 64'd1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic take_b(input logic [3:0] exp_id, input logic [1:0] exp_resp);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin tick(); n++; end
    chk("bvalid", 64'(bvalid), 64'd1);
    chk("bid", 64'(bid), 64'(exp_id));
    chk("bresp", 64'(bresp), 64'(exp_resp));
    tick();
    bready = 1'b0;
    chk("bvalid_after_b", 64'(bvalid), 64'd0);
    chk("awready_after_b", 64'(awready), 64'd1);
  endtask

  task automatic chk_mem(input string tag, input logic [7:0] idx, input logic [31:0] exp);
    dbg_addr = idx; #1;
    chk(tag, 64'(dbg_rdata), 64'(exp));
  endtask

  initial begin
    arst = 1'b0; awaddr = '0; awid = '0; awlen = '0; awburst = '0; awsize = '0;
    awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wid = '0; wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b0; dbg_addr = '0;

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready",  64'(wready),  64'd0);
    chk("rst_bvalid",  64'(bvalid),  64'd0);
    chk("rst_bid",     64'(bid),     64'd0);
    chk("rst_bresp",   64'(bresp),   64'd0);
    arst = 1'b1;
    chk("awready_pre_edge", 64'(awready), 64'd0);
    tick();
    chk("awready_post_rel", 64'(awready), 64'd1);

    // INCR 0x10 len 3 -> words 4..7
    send_aw(32'h10, 4'd5, 4'd3, 2'b01, 3'd2);
    for (int i = 0; i < 4; i++) send_w(32'hA0 + i, 4'hF, 4'd5, i == 3);
    chk("incr_wready_end", 64'(wready), 64'd0);
    chk("incr_bvalid_end", 64'(bvalid), 64'd1);
    take_b(4'd5, 2'b00);
    for (int i = 0; i < 4; i++) chk_mem("incr_mem", 8'(4 + i), 32'hA0 + i);

    // WRAP 0x38 len 3 -> 0x38, 0x3C, 0x30, 0x34
    send_aw(32'h38, 4'd3, 4'd3, 2'b10, 3'd2);
    for (int i = 0; i < 4; i++) send_w(32'hB0 + i, 4'hF, 4'd3, i == 3);
    take_b(4'd3, 2'b00);
    chk_mem("wrap_w14", 8'd14, 32'hB0);
    chk_mem("wrap_w15", 8'd15, 32'hB1);
    chk_mem("wrap_w12", 8'd12, 32'hB2);
    chk_mem("wrap_w13", 8'd13, 32'hB3);

    // FIXED 0x8 len 1 with complementary strobes
    send_aw(32'h8, 4'd1, 4'd1, 2'b00, 3'd2);
    send_w(32'h1111_2222, 4'h3, 4'd1, 1'b0);
    send_w(32'h3333_4444, 4'hC, 4'd1, 1'b1);
    take_b(4'd1, 2'b00);
    chk_mem("fixed_w2", 8'd2, 32'h3333_2222);

    // Seed word 0 so an out-of-range beat aliasing onto it would show
    send_aw(32'h0, 4'd2, 4'd0, 2'b01, 3'd2);
    send_w(32'h1234_5678, 4'hF, 4'd2, 1'b1);
    take_b(4'd2, 2'b00);
    chk_mem("seed_w0", 8'd0, 32'h1234_5678);

    // INCR 0x3FC len 1: second beat beyond memory, plus B backpressure
    send_aw(32'h3FC, 4'd6, 4'd1, 2'b01, 3'd2);
    send_w(32'hDEAD_BEEF, 4'hF, 4'd6, 1'b0);
    send_w(32'hCAFE_F00D, 4'hF, 4'd6, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_bvalid",  64'(bvalid),  64'd1);
      chk("hold_bid",     64'(bid),     64'd6);
      chk("hold_bresp",   64'(bresp),   64'd2);
      chk("hold_awready", 64'(awready), 64'd0);
      tick();
    end
    take_b(4'd6, 2'b10);
    chk_mem("oob_w255", 8'd255, 32'hDEAD_BEEF);
    chk_mem("oob_w0",   8'd0,   32'h1234_5678);

    // Reserved burst type: accepted, not written, SLVERR
    send_aw(32'h0, 4'd4, 4'd0, 2'b11, 3'd2);
    send_w(32'hFFFF_FFFF, 4'hF, 4'd4, 1'b1);
    take_b(4'd4, 2'b10);
    chk_mem("rsvd_w0", 8'd0, 32'h1234_5678);

    // Reset pulse during beat 2 of a len 3 burst
    send_aw(32'h40, 4'd7, 4'd3, 2'b01, 3'd2);
    send_w(32'hC0, 4'hF, 4'd7, 1'b0);
    send_w(32'hC1, 4'hF, 4'd7, 1'b0);
    wdata = 32'hC2; wstrb = 4'hF; wid = 4'd7; wvalid = 1'b1;
    arst = 1'b0;
    #1;
    chk("mid_rst_awready", 64'(awready), 64'd0);
    chk("mid_rst_wready",  64'(wready),  64'd0);
    chk("mid_rst_bvalid",  64'(bvalid),  64'd0);
    chk("mid_rst_bid",     64'(bid),     64'd0);
    chk("mid_rst_bresp",   64'(bresp),   64'd0);
    wvalid = 1'b0;
    tick();
    arst = 1'b1;
    tick();
    chk("post_rst_awready", 64'(awready), 64'd1);
    chk_mem("rst_keep_w16", 8'd16, 32'hC0);
    chk_mem("rst_keep_w17", 8'd17, 32'hC1);
    send_aw(32'h60, 4'd9, 4'd0, 2'b01, 3'd2);
    send_w(32'hE0, 4'hF, 4'd9, 1'b1);
    take_b(4'd9, 2'b00);
    chk_mem("post_rst_w24", 8'd24, 32'hE0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_slave_mem.md
# axi_wr_slave_mem

AXI3-style write-path slave that consumes the write address (AW), write data (W) and write response (B) channels driven by the verification master through the AXI interface's responder-side signals. It accepts one burst at a time, computes FIXED/INCR/WRAP beat addresses, and applies byte strobes into an internal word-addressed memory. It returns OKAY/SLVERR per burst with the captured ID. A combinational debug read port exposes memory contents to the scoreboard.

## Interface
- ADDR_SIZE, 32, address width
- DATA_SIZE, 32, data width; 32 or 64
- STRB_SIZE, DATA_SIZE/8, strobe width
- MEM_DEPTH, 256, memory depth in DATA_SIZE words

Ports:
- aclk  in  1  clock; all logic on posedge
- arst  in  1  reset; asynchronous assert, active-low, synchronous release in use
- awaddr/awid/awlen/awburst/awsize/awlock/awcache/awprot/awvalid  in  ADDR_SIZE/4/4/2/3/2/2/3/1  write address channel
- awready  out  1  AW ready
- wdata/wstrb/wid/wvalid/wlast  in  DATA_SIZE/STRB_SIZE/4/1/1  write data channel
- wready  out  1  W ready
- bid/bresp/bvalid  out  4/2/1  write response channel
- bready  in  1  B ready
- dbg_addr  in  $clog2(MEM_DEPTH)  debug word index
- dbg_rdata  out  DATA_SIZE  combinational memory word at dbg_addr

## Operation
- FSM states: IDLE, DATA, RESP. Reset state IDLE.
- IDLE: awready=1. On awvalid&awready, capture addr, id, len, burst, size; clear beat counter and err flag; go to DATA.
- DATA: wready=1. Each wvalid&wready beat writes byte lanes whose wstrb bit is set at the current beat address, then advances the address. When the beat counter equals captured len, go to RESP.
- RESP: bvalid=1, bid=captured id, bresp=2'b10 if err flag else 2'b00. On bready, go to IDLE.
- Address step is 2^size. FIXED: constant. INCR: addr+step. WRAP: wrap at the aligned boundary of (len+1)*step.
- The err flag is set, and all beats of the burst are accepted but not written, when any of these holds: burst=2'b11; WRAP with len not in {1,3,7,15}; 2^size > STRB_SIZE; WRAP start address unaligned to size.
- The err flag is set, and only the offending beat is dropped, when the beat address is at or beyond MEM_DEPTH*STRB_SIZE or wid differs from the captured id.
- awlock, awcache and awprot are ignored. Exclusive access is treated as normal; EXOKAY is never returned.
- Memory is not cleared by reset and is indeterminate until written.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bid=0, bresp=0. awready rises on the first aclk edge after arst deasserts.
- awready, wready and bvalid are registered state decodes.
- AW handshake in cycle N: wready=1 from cycle N+1. Only one burst is outstanding; awready=0 in DATA and RESP.
- Final beat accepted in cycle M: wready=0 and bvalid=1 from M+1.
- B handshake in cycle K: awready=1 from K+1.
- bvalid, bid and bresp stay stable until bready.
- A memory write is visible on dbg_rdata the cycle after the beat handshake.
- arst asserted mid-burst: FSM returns immediately to IDLE, the partial burst is abandoned, and no response is issued. Already-written beats remain in memory.

## Configuration
- AXI_WR_SLV_WLAST_CHK_EN defined: the err flag is set if wlast=1 on a beat other than beat len, or wlast=0 on beat len. The beat is still written when otherwise legal.
- Undefined: wlast is ignored, and burst end is decided solely by the beat counter.

## Structure
- Package axi_pkg holds:
  - burst typedef (FIXED/INCR/WRAP/RSVD)
  - resp constants (OKAY=2'b00, SLVERR=2'b10)
  - FSM state enum
- Sub-module axi_burst_addr_gen: combinational next-address from addr, burst, size, len.

## Test plan
- INCR, awaddr=0x10, len=3, size=2, wstrb=4'hF, data 0xA0..0xA3 -> words 4..7 hold 0xA0..0xA3; bresp=00; bid=awid.
- WRAP, awaddr=0x38, len=3, size=2 -> beats written to 0x38, 0x3C, 0x30, 0x34; bresp=00.
- FIXED, awaddr=0x8, len=1, wstrb 4'h3 then 4'hC, data 0x1111_2222 then 0x3333_4444 -> word 2 = 0x3333_2222.
- INCR, awaddr=0x3FC, len=1, MEM_DEPTH=256 -> first beat written, second dropped; bresp=10.
- bready held low 5 cycles -> bvalid, bid and bresp stable; awready=0 throughout; awready=1 the cycle after the handshake.
- arst pulse during beat 2 of len=3 -> all outputs at reset values; a following single-beat burst completes with bresp=00.
